// File: rtl/vctrl_ptr_seq_pkg.sv
// Shared constants and state encoding for the VArray loop sequencer.
package vctrl_ptr_seq_pkg;

    localparam int unsigned VRowLoop = 16;
    localparam int unsigned VColLoop = 8;
    localparam int unsigned VRdLat   = 2;

    typedef logic [1:0] VSeqState_t;

    localparam VSeqState_t StIdle  = 2'd0;
    localparam VSeqState_t StRun   = 2'd1;
    localparam VSeqState_t StDrain = 2'd2;
    localparam VSeqState_t StDone  = 2'd3;

endpackage

// File: rtl/vctrl_delay_pipe.sv
// Fixed-latency valid+payload shift register. It never stalls: buffer read
// latency is fixed, so idle slots travel through as bubbles.
module vctrl_delay_pipe #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic [Depth-1:0] valid_q, valid_d;
    logic [Width-1:0] data_q [Depth];
    logic [Width-1:0] data_d [Depth];

    // Shift by one stage; payload of bubbles is zeroed so outputs read 0 when invalid.
    always_comb begin
        valid_d[0] = valid_i;
        data_d[0]  = valid_i ? data_i : '0;
        for (int i = 1; i < Depth; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    // Pipeline registers, flushed by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < Depth; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign valid_o = valid_q[Depth-1];
    assign data_o  = data_q[Depth-1];

endmodule

// File: rtl/vctrl_ptr_seq.sv
// Loop sequencer: walks (rowPtr, colPtr) with rows innermost, and re-times
// each issued point to the buffer read-data cycle via a fixed delay line.
module vctrl_ptr_seq #(
    parameter int unsigned VRowLoop = vctrl_ptr_seq_pkg::VRowLoop,
    parameter int unsigned VColLoop = vctrl_ptr_seq_pkg::VColLoop,
    parameter int unsigned RdLat    = vctrl_ptr_seq_pkg::VRdLat
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [$clog2(VRowLoop):0]   rowLen,
    input  logic [$clog2(VColLoop):0]   colLen,
    input  logic                        stall,
    output logic                        busy,
    output logic                        done,
    output logic                        issue,
    output logic [$clog2(VRowLoop)-1:0] rowPtr,
    output logic [$clog2(VColLoop)-1:0] colPtr,
    output logic                        wbValid,
    output logic [$clog2(VRowLoop)-1:0] wbRowPtr,
    output logic [$clog2(VColLoop)-1:0] wbColPtr,
    output logic                        wbLast
);

    import vctrl_ptr_seq_pkg::*;

    localparam int unsigned RowW    = $clog2(VRowLoop);
    localparam int unsigned ColW    = $clog2(VColLoop);
    localparam int unsigned RowLenW = RowW + 1;
    localparam int unsigned ColLenW = ColW + 1;
    localparam int unsigned PayW    = 1 + ColW + RowW;

    VSeqState_t          state_q, state_d;
    logic [RowLenW-1:0]  row_len_q, row_len_d;
    logic [ColLenW-1:0]  col_len_q, col_len_d;
    logic [RowW-1:0]     row_ptr_q, row_ptr_d;
    logic [ColW-1:0]     col_ptr_q, col_ptr_d;

    logic [RowLenW-1:0]  row_len_clamp;
    logic [ColLenW-1:0]  col_len_clamp;
    logic                row_at_end, col_at_end;
    logic                last_issue;
    logic                wb_valid;
    logic [PayW-1:0]     wb_payload;

    assign row_len_clamp = (rowLen > RowLenW'(VRowLoop)) ? RowLenW'(VRowLoop) : rowLen;
    assign col_len_clamp = (colLen > ColLenW'(VColLoop)) ? ColLenW'(VColLoop) : colLen;

    assign row_at_end = ({1'b0, row_ptr_q} == (row_len_q - RowLenW'(1)));
    assign col_at_end = ({1'b0, col_ptr_q} == (col_len_q - ColLenW'(1)));

    assign issue = (state_q == StRun) && !stall;

    // Next-state: pass framing and pointer walk.
    always_comb begin
        state_d    = state_q;
        row_len_d  = row_len_q;
        col_len_d  = col_len_q;
        row_ptr_d  = row_ptr_q;
        col_ptr_d  = col_ptr_q;
        last_issue = 1'b0;
        case (state_q)
            StIdle: begin
                row_ptr_d = '0;
                col_ptr_d = '0;
                if (start) begin
                    row_len_d = row_len_clamp;
                    col_len_d = col_len_clamp;
                    state_d   = (row_len_clamp == '0 || col_len_clamp == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (issue) begin
                    if (row_at_end) begin
                        row_ptr_d = '0;
                        if (col_at_end) begin
                            // Final point: pointers return to origin while the tail drains.
                            col_ptr_d  = '0;
                            last_issue = 1'b1;
                            state_d    = StDrain;
                        end else begin
                            col_ptr_d = col_ptr_q + ColW'(1);
                        end
                    end else begin
                        row_ptr_d = row_ptr_q + RowW'(1);
                    end
                end
            end
            StDrain: begin
                if (wb_valid && wb_payload[PayW-1]) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                row_ptr_d = '0;
                col_ptr_d = '0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            row_len_q <= '0;
            col_len_q <= '0;
            row_ptr_q <= '0;
            col_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            row_len_q <= row_len_d;
            col_len_q <= col_len_d;
            row_ptr_q <= row_ptr_d;
            col_ptr_q <= col_ptr_d;
        end
    end

    vctrl_delay_pipe #(
        .Depth (RdLat),
        .Width (PayW)
    ) u_delay_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (issue),
        .data_i  ({last_issue, col_ptr_q, row_ptr_q}),
        .valid_o (wb_valid),
        .data_o  (wb_payload)
    );

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign rowPtr   = row_ptr_q;
    assign colPtr   = col_ptr_q;
    assign wbValid  = wb_valid;
    assign wbLast   = wb_payload[PayW-1];
    assign wbColPtr = wb_payload[RowW +: ColW];
    assign wbRowPtr = wb_payload[RowW-1:0];

endmodule

// File: tb/tb_vctrl_ptr_seq.sv
// Scoreboard bench for vctrl_ptr_seq: the driver derives expected issue,
// write-back, busy and done events from the iteration rules and the stall
// pattern it applies; a negedge monitor compares them against the DUT.
module tb_vctrl_ptr_seq;

    localparam int RowLoop = 16;
    localparam int ColLoop = 8;
    localparam int Lat     = 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] rowLen;
    logic [3:0] colLen;
    logic       stall;
    logic       busy, done, issue, wbValid, wbLast;
    logic [3:0] rowPtr, wbRowPtr;
    logic [2:0] colPtr, wbColPtr;

    vctrl_ptr_seq #(
        .VRowLoop (RowLoop),
        .VColLoop (ColLoop),
        .RdLat    (Lat)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rowLen   (rowLen),
        .colLen   (colLen),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .issue    (issue),
        .rowPtr   (rowPtr),
        .colPtr   (colPtr),
        .wbValid  (wbValid),
        .wbRowPtr (wbRowPtr),
        .wbColPtr (wbColPtr),
        .wbLast   (wbLast)
    );

    typedef struct {
        int cyc;
        int row;
        int col;
        bit last;
    } ev_t;

    ev_t iq[$];
    ev_t wq[$];

    int cyc       = 0;
    int done_cyc  = -1;
    int busy_from = -1;
    int busy_to   = -1;
    int next_idle = 0;
    int checks    = 0;
    int errors    = 0;
    int stall_pct = 0;
    bit hold      = 0;
    bit mon_en    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Advance into the next cycle and drive this cycle's inputs.
    task automatic step();
        @(posedge clk);
        #1;
        start = hold;
        stall = ($urandom_range(99) < stall_pct);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        iq.delete();
        wq.delete();
        done_cyc  = -1;
        busy_from = -1;
        busy_to   = -1;
        hold      = 1'b0;
        start     = 1'b0;
        #1;
        check("reset_outputs_zero",
              int'({busy, done, issue, rowPtr, colPtr, wbValid, wbRowPtr, wbColPtr, wbLast}), 0);
        step();
        step();
        rst_n = 1'b1;
        next_idle = cyc + 1;
    endtask

    // One pass: expected points follow row-inner/col-outer order; each
    // non-stalled cycle after acceptance issues the next point.
    task automatic run_pass(input int rl, input int cl, input bit use_mask,
                            input logic [31:0] mask, input int rst_at, input bit hold_pass);
        int  rlc, clc, c, k, idx;
        ev_t pts[$];
        ev_t e;
        while (cyc < next_idle) step();
        rlc = (rl > RowLoop) ? RowLoop : rl;
        clc = (cl > ColLoop) ? ColLoop : cl;
        for (int col = 0; col < clc; col++) begin
            for (int row = 0; row < rlc; row++) begin
                e.cyc  = 0;
                e.row  = row;
                e.col  = col;
                e.last = (row == rlc - 1) && (col == clc - 1);
                pts.push_back(e);
            end
        end
        start     = 1'b1;
        rowLen    = 5'(rl);
        colLen    = 4'(cl);
        c         = cyc;
        hold      = hold_pass;
        busy_from = c + 1;
        busy_to   = 1 << 30;
        done_cyc  = -1;
        if (pts.size() == 0) begin
            done_cyc  = c + 1;
            busy_to   = c + 1;
            next_idle = c + 2;
            return;
        end
        idx = 0;
        k   = c;
        while (idx < pts.size()) begin
            step();
            k = cyc;
            if (rst_at > 0 && k == c + rst_at) begin
                do_reset();
                return;
            end
            if (use_mask) stall = ((k - c) < 32) ? mask[k-c] : 1'b0;
            if (!stall) begin
                e     = pts[idx];
                e.cyc = k;
                iq.push_back(e);
                e.cyc = k + Lat;
                wq.push_back(e);
                idx++;
            end
        end
        done_cyc  = k + Lat + 1;
        busy_to   = done_cyc;
        next_idle = done_cyc + 1;
    endtask

    ev_t m_e;
    bit  m_now;

    // Monitor: compare DUT outputs against scoreboard expectations mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", int'(busy), int'(cyc >= busy_from && cyc <= busy_to));
            if (done || cyc == done_cyc) check("done", int'(done), int'(cyc == done_cyc));

            m_now = (iq.size() > 0) && (iq[0].cyc == cyc);
            if (issue || m_now) begin
                check("issue", int'(issue), int'(m_now));
                if (m_now) begin
                    m_e = iq.pop_front();
                    if (issue) check("issue_row_col", int'(rowPtr) * 256 + int'(colPtr),
                                     m_e.row * 256 + m_e.col);
                end
            end

            m_now = (wq.size() > 0) && (wq[0].cyc == cyc);
            if (wbValid || m_now) begin
                check("wb_valid", int'(wbValid), int'(m_now));
                if (m_now) begin
                    m_e = wq.pop_front();
                    if (wbValid) check("wb_last_row_col",
                                       int'(wbLast) * 65536 + int'(wbRowPtr) * 256 + int'(wbColPtr),
                                       int'(m_e.last) * 65536 + m_e.row * 256 + m_e.col);
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        stall  = 1'b0;
        rowLen = '0;
        colLen = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state",
              int'({busy, done, issue, rowPtr, colPtr, wbValid, wbRowPtr, wbColPtr, wbLast}), 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        next_idle = cyc + 1;

        stall_pct = 0;
        run_pass(4, 2, 1'b0, 32'h0, 0, 1'b0);
        run_pass(4, 2, 1'b1, 32'h18, 0, 1'b0);   // stall in relative cycles 3-4
        run_pass(0, 5, 1'b0, 32'h0, 0, 1'b0);
        run_pass(5, 0, 1'b0, 32'h0, 0, 1'b0);
        run_pass(31, 8, 1'b0, 32'h0, 0, 1'b0);
        run_pass(16, 15, 1'b0, 32'h0, 0, 1'b0);
        run_pass(4, 2, 1'b0, 32'h0, 5, 1'b0);    // reset mid-pass
        run_pass(4, 2, 1'b0, 32'h0, 0, 1'b0);
        run_pass(3, 3, 1'b0, 32'h0, 0, 1'b1);    // start held through pass and done
        run_pass(2, 2, 1'b0, 32'h0, 0, 1'b0);
        run_pass(1, 1, 1'b0, 32'h0, 0, 1'b0);

        stall_pct = 30;
        for (int p = 0; p < 14; p++) begin
            run_pass(int'($urandom_range(0, 20)), int'($urandom_range(0, 10)), 1'b0, 32'h0, 0,
                     1'($urandom_range(0, 1)));
        end
        hold = 1'b0;

        while (cyc < next_idle + 4) step();
        check("issue_queue_drained", iq.size(), 0);
        check("wb_queue_drained", wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vctrl_ptr_seq.md
# vctrl_ptr_seq

Loop sequencer for the VArray vector datapath. It walks the (rowPtr, colPtr) iteration space with rowPtr innermost and colPtr outermost, one point per issued cycle. The pointers drive the VArray address converter, which derives OBuf/EBuf/VBuf addresses and the OBuf bank-half select from them. A fixed-latency delay line re-times each issued pointer pair to the cycle its buffer read data returns, so write-back/compute logic gets an aligned valid, pointers and last flag. A start/busy/done handshake frames each pass, and a stall input throttles issue.

## Interface
Parameters:
- VRowLoop, 16 (from Common): maximum row iterations; power of two.
- VColLoop, 8 (from Common): maximum column iterations; power of two.
- RdLat, 2 (from Common, VRdLat): address-to-data latency of the buffers, ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a pass; sampled only in IDLE.
- rowLen  in  $clog2(VRowLoop)+1  rows this pass, latched on accepted start; values >VRowLoop clamp to VRowLoop.
- colLen  in  $clog2(VColLoop)+1  columns this pass, latched and clamped likewise.
- stall  in  1  blocks issue for the current cycle.
- busy  out  1  high in RUN, DRAIN and DONE.
- done  out  1  one-cycle pulse at pass end.
- issue  out  1  rowPtr/colPtr form a valid address this cycle.
- rowPtr  out  $clog2(VRowLoop)  current row pointer.
- colPtr  out  $clog2(VColLoop)  current column pointer.
- wbValid  out  1  issue delayed by exactly RdLat cycles.
- wbRowPtr  out  $clog2(VRowLoop)  rowPtr delayed RdLat.
- wbColPtr  out  $clog2(VColLoop)  colPtr delayed RdLat.
- wbLast  out  1  marks the final point of the pass, aligned with wbValid.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start, latch the clamped lengths. If either length is 0, go to DONE with no issue; otherwise go to RUN. Pointers are held at 0.
- RUN: issue = !stall. On issue:
  - rowPtr increments.
  - At rowPtr == rowLen-1, rowPtr wraps to 0 and colPtr increments.
  - At (rowLen-1, colLen-1), the issue is flagged last and the next state is DRAIN.
- While stall is high, the pointers hold. The delay line always shifts, because buffer latency is fixed; a stalled cycle inserts a bubble (wbValid=0).
- DRAIN: wait until the last-flagged entry exits the delay line (wbValid && wbLast), then go to DONE.
- DONE: done=1 for one cycle; pointers clear to 0; next state is IDLE.
- start outside IDLE is ignored. stall outside RUN has no effect.
- Each accepted pass issues exactly rowLen·colLen points, each (row, col) once, in order.
- Reset (any state, including mid-pass): state=IDLE, every output 0, delay line flushed. No wbValid is produced for points issued before reset.

## Timing
- start sampled at edge 0 → RUN from cycle 1. First issue in cycle 1 at (0,0) unless stall.
- With N = rowLen·colLen and no stall: last issue in cycle N; wbValid in cycles 1+RdLat .. N+RdLat; wbLast in cycle N+RdLat; done in cycle N+RdLat+1; busy in cycles 1 .. N+RdLat+1; IDLE from cycle N+RdLat+2.
- Each stalled RUN cycle delays all later events by one cycle.
- Zero-length pass: done in cycle 1; issue and wbValid never assert.
- Back-to-back: a start that coincides with done is ignored. The earliest next accept is the first IDLE cycle.
- issue, rowPtr and colPtr are registered-state-derived; issue may combine the state with stall. All wb* outputs are registered.

## Structure
- Common package: VRowLoop, VColLoop, VRdLat, and the state enum typedef VSeqState_t.
- Sub-module vctrl_delay_pipe: parameterised depth (RdLat) and payload width. It is a valid+payload shift register with asynchronous active-low clear and no stall input. It carries {last, colPtr, rowPtr}.

## Test plan
- rowLen=4, colLen=2, RdLat=2, no stall: issue in cycles 1–8 with (row,col) = (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1); wbLast in cycle 10; done in cycle 11; busy in cycles 1–11.
- Same pass with stall high in cycles 3–4: points (0,0),(1,0) issue in cycles 1–2; (2,0) issues in cycle 5; wbValid is 0 in cycles 5–6; done in cycle 13.
- rowLen=0, colLen=5: done in cycle 1; issue and wbValid stay 0.
- rowLen=31, colLen=8 (VRowLoop=16): clamps to 16×8; 128 issues; pointers reach (15,7) then return to 0.
- Reset asserted in cycle 5 of the first pass: all outputs 0 immediately; no wbValid afterwards. A new start after release begins at (0,0).
- start held high through a whole pass and the done cycle: only one pass runs; the second pass starts from the first IDLE cycle.
